// File: rtl/imm_pkg.sv
// Shared widths and mode encoding for the RISC-V immediate extender.
// The mode is formed from {ext_op, unsigned_op}; ext_op takes priority.
package imm_pkg;

    localparam int IMM_IN_W    = 20;
    localparam int IMM_SHORT_W = 12;
    localparam int XLEN        = 32;

    typedef enum logic [1:0] {
        SEXT12 = 2'b00,
        ZEXT12 = 2'b01,
        SEXT20 = 2'b10
    } imm_mode_e;

    // ext_op wins over unsigned_op, so {1,x} always collapses to SEXT20.
    function automatic imm_mode_e decode_mode(input logic ext_op, input logic unsigned_op);
        imm_mode_e mode;
        if (ext_op) begin
            mode = SEXT20;
        end else if (unsigned_op) begin
            mode = ZEXT12;
        end else begin
            mode = SEXT12;
        end
        return mode;
    endfunction

endpackage : imm_pkg

// File: rtl/imm_extd_core.sv
// Purely combinational immediate extender: mode + raw operand -> full-width value.
// Usable unregistered by decode logic that cannot afford the output flop.
module imm_extd_core
    import imm_pkg::*;
#(
    parameter int IN_W    = IMM_IN_W,
    parameter int SHORT_W = IMM_SHORT_W,
    parameter int OUT_W   = XLEN
) (
    input  imm_mode_e          mode,
    input  logic [IN_W-1:0]    operand,
    output logic [OUT_W-1:0]   value
);

    logic [SHORT_W-1:0] short_field;

    assign short_field = operand[SHORT_W-1:0];

    always_comb begin
        // NOTE: default assignment first so every path drives value; no latch can be inferred.
        value = '0;
        case (mode)
            SEXT12:  value = {{(OUT_W-SHORT_W){short_field[SHORT_W-1]}}, short_field};
            ZEXT12:  value = {{(OUT_W-SHORT_W){1'b0}}, short_field};
            default: value = {{(OUT_W-IN_W){operand[IN_W-1]}}, operand};
        endcase
    end

endmodule : imm_extd_core

// File: rtl/imm_extd.sv
// Registered immediate extender: one cycle from operand/mode to result.
// Result is cleared asynchronously while rst is high.
module imm_extd
    import imm_pkg::*;
#(
    parameter int IN_W    = IMM_IN_W,
    parameter int SHORT_W = IMM_SHORT_W,
    parameter int OUT_W   = XLEN
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ext_op,
    input  logic               unsigned_op,
    input  logic [IN_W-1:0]    operand_a,
    output logic [OUT_W-1:0]   result
);

    imm_mode_e        mode;
    logic [OUT_W-1:0] ext_value;

    assign mode = decode_mode(ext_op, unsigned_op);

    imm_extd_core #(
        .IN_W    (IN_W),
        .SHORT_W (SHORT_W),
        .OUT_W   (OUT_W)
    ) u_core (
        .mode    (mode),
        .operand (operand_a),
        .value   (ext_value)
    );

    // NOTE: non-blocking assignment for the state register; the async reset sits in the sensitivity list.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result <= '0;
        end else begin
            result <= ext_value;
        end
    end

endmodule : imm_extd

// File: tb/tb_imm_extd.sv
// Directed self-checking bench for imm_extd: reset, all three modes, priority and latency.
module tb_imm_extd;

    logic        clk;
    logic        rst;
    logic        ext_op;
    logic        unsigned_op;
    logic [19:0] operand_a;
    logic [31:0] result;

    int tests_run;
    int tests_failed;

    imm_extd dut (
        .clk         (clk),
        .rst         (rst),
        .ext_op      (ext_op),
        .unsigned_op (unsigned_op),
        .operand_a   (operand_a),
        .result      (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] expected);
        tests_run++;
        assert (result === expected) else begin
            tests_failed++;
            $error("FAIL %s: observed=%h expected=%h", tag, result, expected);
        end
    endtask

    // Drive inputs away from the edge, let one rising edge capture, sample 1 time unit later.
    task automatic step(input string tag, input logic e, input logic u,
                        input logic [19:0] a, input logic [31:0] expected);
        @(negedge clk);
        ext_op      = e;
        unsigned_op = u;
        operand_a   = a;
        @(posedge clk);
        #1;
        check(tag, expected);
    endtask

    logic [19:0] lat_a   [6];
    logic        lat_e   [6];
    logic        lat_u   [6];
    logic [31:0] lat_exp [6];
    logic [31:0] prev_exp;

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        ext_op       = 1'b1;
        unsigned_op  = 1'b0;
        operand_a    = 20'hFFFFF;

        #1;
        check("reset_initial", 32'h0000_0000);
        @(posedge clk);
        #1;
        check("reset_held_over_edge", 32'h0000_0000);

        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_release_no_edge", 32'h0000_0000);

        // SEXT20
        step("sext20_fffff", 1'b1, 1'b0, 20'hFFFFF, 32'hFFFF_FFFF);
        step("sext20_7ffff", 1'b1, 1'b0, 20'h7FFFF, 32'h0007_FFFF);
        step("sext20_8000f", 1'b1, 1'b0, 20'h8000F, 32'hFFF8_000F);
        step("sext20_00001", 1'b1, 1'b0, 20'h00001, 32'h0000_0001);

        // SEXT12: upper operand bits ignored
        step("sext12_007ff", 1'b0, 1'b0, 20'h007FF, 32'h0000_07FF);
        step("sext12_fffff", 1'b0, 1'b0, 20'hFFFFF, 32'hFFFF_FFFF);
        step("sext12_7f000", 1'b0, 1'b0, 20'h7F000, 32'h0000_0000);
        step("sext12_8000f", 1'b0, 1'b0, 20'h8000F, 32'h0000_000F);

        // ZEXT12
        step("zext12_fffff", 1'b0, 1'b1, 20'hFFFFF, 32'h0000_0FFF);
        step("zext12_00800", 1'b0, 1'b1, 20'h00800, 32'h0000_0800);
        step("zext12_00000", 1'b0, 1'b1, 20'h00000, 32'h0000_0000);

        // ext_op overrides unsigned_op
        step("prio_ext_over_u", 1'b1, 1'b1, 20'h80000, 32'hFFF8_0000);

        // Async reset mid-stream with result all ones
        step("pre_reset_ones", 1'b1, 1'b0, 20'hFFFFF, 32'hFFFF_FFFF);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("reset_async_clear", 32'h0000_0000);
        @(posedge clk);
        #1;
        check("reset_hold_edge", 32'h0000_0000);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_release_wait", 32'h0000_0000);
        @(posedge clk);
        #1;
        check("reset_first_capture", 32'hFFFF_FFFF);

        // Back-to-back latency: new operand every cycle
        lat_a[0] = 20'h00123; lat_e[0] = 1'b0; lat_u[0] = 1'b0; lat_exp[0] = 32'h0000_0123;
        lat_a[1] = 20'h00A5A; lat_e[1] = 1'b0; lat_u[1] = 1'b0; lat_exp[1] = 32'hFFFF_FA5A;
        lat_a[2] = 20'h00A5A; lat_e[2] = 1'b0; lat_u[2] = 1'b1; lat_exp[2] = 32'h0000_0A5A;
        lat_a[3] = 20'hC0001; lat_e[3] = 1'b1; lat_u[3] = 1'b0; lat_exp[3] = 32'hFFFC_0001;
        lat_a[4] = 20'h40F00; lat_e[4] = 1'b1; lat_u[4] = 1'b1; lat_exp[4] = 32'h0004_0F00;
        lat_a[5] = 20'h5A800; lat_e[5] = 1'b0; lat_u[5] = 1'b0; lat_exp[5] = 32'hFFFF_F800;
        prev_exp = 32'hFFFF_FFFF;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            ext_op      = lat_e[i];
            unsigned_op = lat_u[i];
            operand_a   = lat_a[i];
            #1;
            check($sformatf("lat_hold_%0d", i), prev_exp);
            @(posedge clk);
            #1;
            check($sformatf("lat_capture_%0d", i), lat_exp[i]);
            prev_exp = lat_exp[i];
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_imm_extd
